// File: rtl/ws2812_scheduler.sv
// Frame scheduler for a WS2812 LED chain: arbitrates two pixel writers into a
// pixel buffer and streams the buffer to the bit encoder, followed by a latch gap.
module ws2812_scheduler #(
   parameter int NUM_LEDS    = 8,
   parameter int ADDR_W      = 3,
   parameter int CLK_FRE     = 27_000_000,
   parameter int LATCH_US    = 80,
   parameter int REFRESH_CYC = 2_700_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [23:0]       a_rgb,
   output logic              a_gnt,
   input  logic              b_req,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [23:0]       b_rgb,
   output logic              b_gnt,
   output logic              pix_valid,
   output logic [23:0]       pix_data,
   input  logic              pix_ready,
   output logic              busy,
   output logic              frame_done
);

   localparam int LATCH_CYC = CLK_FRE / 1_000_000 * LATCH_US;
   localparam int LATCH_TC  = (LATCH_CYC > 0) ? LATCH_CYC - 1 : 0;
   localparam int DEPTH     = 1 << ADDR_W;

   typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, LATCH = 2'd2} state_t;

   state_t            state_r, state_nxt_s;
   logic [23:0]       pix_buf_r [DEPTH];
   logic              dirty_r, prio_b_r, pix_valid_r;
   logic [23:0]       pix_data_r;
   logic [ADDR_W-1:0] idx_r;
   logic [31:0]       rcnt_r, lcnt_r;
   logic              start_s, refresh_due_s, gnt_ok_s, a_gnt_s, b_gnt_s;
   logic              hs_s, last_s, latch_tc_s, wr_en_s;
   logic [ADDR_W-1:0] wr_addr_s;
   logic [23:0]       wr_rgb_s;

   // Next state, frame start and round-robin grant decision
   always_comb begin
      state_nxt_s   = state_r;
      start_s       = 1'b0;
      gnt_ok_s      = 1'b0;
      a_gnt_s       = 1'b0;
      b_gnt_s       = 1'b0;
      refresh_due_s = (REFRESH_CYC != 0) && (rcnt_r == 32'(REFRESH_CYC - 1));
      hs_s          = (state_r == SEND) && pix_valid_r && pix_ready;
      last_s        = (idx_r == ADDR_W'(NUM_LEDS - 1));
      latch_tc_s    = (lcnt_r == 32'(LATCH_TC));
      case (state_r)
         IDLE: begin
            if (dirty_r || refresh_due_s) begin
               start_s     = 1'b1;
               state_nxt_s = SEND;
            end else begin
               gnt_ok_s    = 1'b1;
            end
         end
         SEND: begin
            if (hs_s && last_s) begin
               state_nxt_s = LATCH;
            end else begin
               state_nxt_s = SEND;
            end
         end
         LATCH: begin
            gnt_ok_s = 1'b1;
            if (latch_tc_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = LATCH;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
      // Grants are combinational, so reset must mask them directly
      if (gnt_ok_s && rst_n) begin
         if (a_req && (!b_req || !prio_b_r)) begin
            a_gnt_s = 1'b1;
         end else if (b_req) begin
            b_gnt_s = 1'b1;
         end else begin
            a_gnt_s = 1'b0;
            b_gnt_s = 1'b0;
         end
      end else begin
         a_gnt_s = 1'b0;
         b_gnt_s = 1'b0;
      end
   end

   // Select the granted write and drop out-of-range addresses
   always_comb begin
      if (a_gnt_s) begin
         wr_addr_s = a_addr;
         wr_rgb_s  = a_rgb;
      end else begin
         wr_addr_s = b_addr;
         wr_rgb_s  = b_rgb;
      end
      wr_en_s = (a_gnt_s || b_gnt_s) && (32'(wr_addr_s) < 32'(NUM_LEDS));
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Round-robin pointer: the requester granted last loses the next tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_b_r <= 1'b0;
      end else if (a_gnt_s) begin
         prio_b_r <= 1'b1;
      end else if (b_gnt_s) begin
         prio_b_r <= 1'b0;
      end else begin
         prio_b_r <= prio_b_r;
      end
   end

   // Pixel buffer and dirty flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) pix_buf_r[i] <= 24'd0;
         dirty_r <= 1'b0;
      end else begin
         if (wr_en_s) begin
            pix_buf_r[wr_addr_s] <= wr_rgb_s;
         end
         if (start_s) begin
            dirty_r <= 1'b0;
         end else if (wr_en_s) begin
            dirty_r <= 1'b1;
         end else begin
            dirty_r <= dirty_r;
         end
      end
   end

   // Refresh and latch-gap counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcnt_r <= 32'd0;
         lcnt_r <= 32'd0;
      end else begin
         if (start_s) begin
            rcnt_r <= 32'd0;
         end else if ((state_r == IDLE) && (REFRESH_CYC != 0)) begin
            rcnt_r <= rcnt_r + 32'd1;
         end else begin
            rcnt_r <= rcnt_r;
         end
         if ((state_r == LATCH) && !latch_tc_s) begin
            lcnt_r <= lcnt_r + 32'd1;
         end else begin
            lcnt_r <= 32'd0;
         end
      end
   end

   // Pixel stream: next pixel is preloaded on each handshake so there is no bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r       <= '0;
         pix_valid_r <= 1'b0;
         pix_data_r  <= 24'd0;
      end else if (start_s) begin
         idx_r       <= '0;
         pix_valid_r <= 1'b1;
         pix_data_r  <= pix_buf_r[0];
      end else if (hs_s) begin
         if (last_s) begin
            idx_r       <= '0;
            pix_valid_r <= 1'b0;
            pix_data_r  <= 24'd0;
         end else begin
            idx_r       <= idx_r + ADDR_W'(1);
            pix_valid_r <= 1'b1;
            pix_data_r  <= pix_buf_r[idx_r + ADDR_W'(1)];
         end
      end else begin
         idx_r       <= idx_r;
         pix_valid_r <= pix_valid_r;
         pix_data_r  <= pix_data_r;
      end
   end

   assign a_gnt      = a_gnt_s;
   assign b_gnt      = b_gnt_s;
   assign pix_valid  = pix_valid_r;
   assign pix_data   = pix_data_r;
   assign busy       = (state_r != IDLE);
   assign frame_done = (state_r == LATCH) && latch_tc_s;

endmodule

// File: tb/tb_ws2812_scheduler.sv
// Directed bench for ws2812_scheduler: 4 LEDs, 10-cycle latch; a second
// instance with a 50-cycle refresh interval checks periodic frames.
module tb_ws2812_scheduler;

   logic        clk;
   logic        rst_n, rst2_n;
   logic        a_req, b_req, pix_ready;
   logic [2:0]  a_addr, b_addr;
   logic [23:0] a_rgb, b_rgb;
   logic        a_gnt, b_gnt, pix_valid, busy, frame_done;
   logic [23:0] pix_data;

   logic        r_a_req, r_b_req, r_pix_ready;
   logic [2:0]  r_a_addr, r_b_addr;
   logic [23:0] r_a_rgb, r_b_rgb;
   logic        r_a_gnt, r_b_gnt, r_pix_valid, r_busy, r_frame_done;
   logic [23:0] r_pix_data;

   int n_tests = 0;
   int n_fail  = 0;

   ws2812_scheduler #(.NUM_LEDS(4), .ADDR_W(3), .CLK_FRE(1_000_000), .LATCH_US(10),
                      .REFRESH_CYC(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_addr(a_addr), .a_rgb(a_rgb), .a_gnt(a_gnt),
      .b_req(b_req), .b_addr(b_addr), .b_rgb(b_rgb), .b_gnt(b_gnt),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
      .busy(busy), .frame_done(frame_done));

   ws2812_scheduler #(.NUM_LEDS(4), .ADDR_W(3), .CLK_FRE(1_000_000), .LATCH_US(10),
                      .REFRESH_CYC(50)) dut_ref (
      .clk(clk), .rst_n(rst2_n),
      .a_req(r_a_req), .a_addr(r_a_addr), .a_rgb(r_a_rgb), .a_gnt(r_a_gnt),
      .b_req(r_b_req), .b_addr(r_b_addr), .b_rgb(r_b_rgb), .b_gnt(r_b_gnt),
      .pix_valid(r_pix_valid), .pix_data(r_pix_data), .pix_ready(r_pix_ready),
      .busy(r_busy), .frame_done(r_frame_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Expects SEND at idx0 now with pix_ready high; ends on the first LATCH cycle
   task automatic frame(input logic [23:0] p0, input logic [23:0] p1,
                        input logic [23:0] p2, input logic [23:0] p3);
      logic [23:0] exp_px [4];
      exp_px = '{p0, p1, p2, p3};
      for (int i = 0; i < 4; i++) begin
         chk("frame_valid", 32'(pix_valid), 32'd1);
         chk("frame_data", 32'(pix_data), 32'(exp_px[i]));
         chk("frame_no_gnt", 32'({a_gnt, b_gnt}), 32'd0);
         chk("frame_busy", 32'(busy), 32'd1);
         tick();
      end
      chk("latch_valid_low", 32'(pix_valid), 32'd0);
   endtask

   task automatic latch_rest(input int from);
      for (int i = from; i < 10; i++) begin
         chk("latch_frame_done", 32'(frame_done), (i == 9) ? 32'd1 : 32'd0);
         chk("latch_busy", 32'(busy), 32'd1);
         tick();
      end
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_frame_done", 32'(frame_done), 32'd0);
   endtask

   initial begin
      logic [23:0] eb [4];
      int          idx, hs, k, m, hi;
      logic        bad;

      rst_n = 1'b0; rst2_n = 1'b0;
      a_req = 1'b0; a_addr = 3'd0; a_rgb = 24'd0;
      b_req = 1'b0; b_addr = 3'd0; b_rgb = 24'd0;
      pix_ready = 1'b1;
      r_a_req = 1'b0; r_a_addr = 3'd0; r_a_rgb = 24'd0;
      r_b_req = 1'b0; r_b_addr = 3'd0; r_b_rgb = 24'd0;
      r_pix_ready = 1'b1;

      // Reset state
      repeat (3) tick();
      chk("rst_pix_valid", 32'(pix_valid), 32'd0);
      chk("rst_pix_data", 32'(pix_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_gnt", 32'({a_gnt, b_gnt}), 32'd0);
      rst_n = 1'b1;

      // Both requesters held: A first after reset, then B, A, B in LATCH
      a_req = 1'b1; a_addr = 3'd0; a_rgb = 24'h0000AA;
      b_req = 1'b1; b_addr = 3'd3; b_rgb = 24'h0000BB;
      #1;
      chk("rr_first_a", 32'({a_gnt, b_gnt}), 32'd2);
      tick();
      chk("rr_start_blocks", 32'({a_gnt, b_gnt}), 32'd0);
      tick();
      frame(24'h0000AA, 24'd0, 24'd0, 24'd0);
      chk("rr_second_b", 32'({a_gnt, b_gnt}), 32'd1);
      tick();
      chk("rr_third_a", 32'({a_gnt, b_gnt}), 32'd2);
      tick();
      chk("rr_fourth_b", 32'({a_gnt, b_gnt}), 32'd1);
      a_req = 1'b0; b_req = 1'b0;
      tick();
      latch_rest(3);
      tick();
      frame(24'h0000AA, 24'd0, 24'd0, 24'h0000BB);
      latch_rest(0);
      repeat (3) tick();
      chk("rr_settled_idle", 32'(busy), 32'd0);

      // Reset pulse in IDLE clears buffer
      rst_n = 1'b0;
      #1;
      chk("rst2_busy", 32'(busy), 32'd0);
      tick();
      rst_n = 1'b1;

      // Single write A addr 2
      a_req = 1'b1; a_addr = 3'd2; a_rgb = 24'h00FF00;
      #1;
      chk("single_a_gnt", 32'({a_gnt, b_gnt}), 32'd2);
      tick();
      a_req = 1'b0;
      #1;
      chk("single_pre_send_busy", 32'(busy), 32'd0);
      tick();
      frame(24'd0, 24'd0, 24'h00FF00, 24'd0);
      latch_rest(0);

      // Stall pattern 1,0,0,1,... with a bench-side pixel model
      a_req = 1'b1; a_addr = 3'd1; a_rgb = 24'h123456;
      #1;
      chk("stall_a_gnt", 32'(a_gnt), 32'd1);
      tick();
      a_req = 1'b0;
      tick();
      eb = '{24'd0, 24'h123456, 24'h00FF00, 24'd0};
      idx = 0; hs = 0; k = 0;
      while (hs < 4 && k < 40) begin
         chk("stall_valid", 32'(pix_valid), 32'd1);
         chk("stall_data", 32'(pix_data), 32'(eb[idx]));
         pix_ready = (k % 3 == 0);
         tick();
         if (pix_ready) begin
            idx++;
            hs++;
         end
         k++;
      end
      chk("stall_end_valid_low", 32'(pix_valid), 32'd0);
      pix_ready = 1'b1;
      latch_rest(0);

      // B held during SEND is only granted in LATCH; its write starts the next frame
      a_req = 1'b1; a_addr = 3'd3; a_rgb = 24'hABCDEF;
      #1;
      chk("hold_a_gnt", 32'(a_gnt), 32'd1);
      tick();
      a_req = 1'b0;
      b_req = 1'b1; b_addr = 3'd0; b_rgb = 24'h0F0F0F;
      #1;
      chk("hold_start_no_b", 32'(b_gnt), 32'd0);
      tick();
      frame(24'd0, 24'h123456, 24'h00FF00, 24'hABCDEF);
      chk("hold_b_in_latch", 32'({a_gnt, b_gnt}), 32'd1);
      tick();
      b_req = 1'b0;
      latch_rest(1);
      tick();
      frame(24'h0F0F0F, 24'h123456, 24'h00FF00, 24'hABCDEF);
      latch_rest(0);

      // Out-of-range address: granted, no frame
      a_req = 1'b1; a_addr = 3'd5; a_rgb = 24'hFFFFFF;
      #1;
      chk("oor_gnt", 32'(a_gnt), 32'd1);
      tick();
      a_req = 1'b0;
      bad = 1'b0;
      repeat (20) begin
         tick();
         if (busy || pix_valid) bad = 1'b1;
      end
      chk("oor_no_frame", 32'(bad), 32'd0);

      // Reset after the second pixel handshake
      a_req = 1'b1; a_addr = 3'd0; a_rgb = 24'h55AA55;
      #1;
      chk("midrst_a_gnt", 32'(a_gnt), 32'd1);
      tick();
      a_req = 1'b0;
      tick();
      chk("midrst_px0", 32'(pix_data), 32'h55AA55);
      tick();
      tick();
      chk("midrst_px2", 32'(pix_data), 32'h00FF00);
      rst_n = 1'b0;
      a_req = 1'b1; a_addr = 3'd1; a_rgb = 24'h000001;
      #1;
      chk("midrst_valid", 32'(pix_valid), 32'd0);
      chk("midrst_data", 32'(pix_data), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_gnt_masked", 32'(a_gnt), 32'd0);
      a_req = 1'b0;
      tick();
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (30) begin
         tick();
         if (busy || pix_valid) bad = 1'b1;
      end
      chk("midrst_no_frame", 32'(bad), 32'd0);
      a_req = 1'b1; a_addr = 3'd1; a_rgb = 24'h000001;
      #1;
      chk("midrst_new_gnt", 32'(a_gnt), 32'd1);
      tick();
      a_req = 1'b0;
      tick();
      frame(24'd0, 24'h000001, 24'd0, 24'd0);
      latch_rest(0);

      // Periodic refresh on the second instance: first frame after 50 idle cycles
      rst2_n = 1'b1;
      m = 0;
      while (!r_pix_valid && m < 100) begin
         tick();
         m++;
      end
      chk("refresh_first_start", 32'(m), 32'd50);
      chk("refresh_zero_pixel", 32'(r_pix_data), 32'd0);
      m = 0; hi = 0;
      while (r_pix_valid && m < 200) begin
         tick();
         m++;
         hi++;
      end
      chk("refresh_pixel_count", 32'(hi), 32'd4);
      while (!r_pix_valid && m < 200) begin
         tick();
         m++;
      end
      chk("refresh_period", 32'(m), 32'd64);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
